speed_calc: RTL and testbench

Parametrised successor of the per-shot speed setter for the artillery game. It accepts a launch request and selects the shooter's power from the current player and turn. It applies signed wind with saturation into a configurable speed window, then holds the speed through the projectile's flight. During flight, a frame-tick-driven drag decay reduces the speed. It sits between the power/turn control and the trajectory generator, and gives the trajectory block a valid-qualified speed plus a busy flag.

---
 rtl/variable_pkg.sv | 14 +
 rtl/speed_calc_if.sv | 36 +++
 rtl/wind_apply.sv | 54 +++++
 rtl/speed_calc.sv | 125 ++++++++++++
 tb/tb_speed_calc.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/variable_pkg.sv
// Shared definitions for the artillery game blocks.
// Player codes and the speed calculator state encoding.
package variable_pkg;

    localparam logic [1:0] PLAYER_1 = 2'b01;
    localparam logic [1:0] PLAYER_2 = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FLIGHT
    } speed_state_t;

endpackage

// File: rtl/speed_calc_if.sv
// Launch/speed bundle between turn control, speed_calc and the
// trajectory generator.
interface speed_calc_if #(
    parameter int PW = 5,
    parameter int WW = 2
);
    logic          launch;
    logic          launch_ready;
    logic [1:0]    current_player;
    logic          turn;
    logic [PW-1:0] in_power;
    logic [PW-1:0] power;
    logic [WW:0]   wind;
    logic          frame_tick;
    logic          hit;
    logic [PW-1:0] speed;
    logic          speed_valid;
    logic          saturated;
    logic          busy;

    modport master (
        output launch, current_player, turn,
        output in_power, power, wind,
        output frame_tick, hit,
        input  launch_ready, speed, speed_valid,
        input  saturated, busy
    );

    modport slave (
        input  launch, current_player, turn,
        input  in_power, power, wind,
        input  frame_tick, hit,
        output launch_ready, speed, speed_valid,
        output saturated, busy
    );
endinterface

// File: rtl/wind_apply.sv
// Combinational launch speed: power source select, signed wind
// add/subtract and clamp into [SPEED_MIN, SPEED_MAX].
module wind_apply
    import variable_pkg::*;
#(
    parameter int PW        = 5,
    parameter int WW        = 2,
    parameter int SPEED_MIN = 1,
    parameter int SPEED_MAX = 31
) (
    input  logic [1:0]    player,
    input  logic          turn,
    input  logic [PW-1:0] in_power,
    input  logic [PW-1:0] power,
    input  logic [WW:0]   wind,
    output logic [PW-1:0] result,
    output logic          saturated
);
    localparam int XW = PW + 2;
    localparam logic signed [XW-1:0] LO = XW'(SPEED_MIN);
    localparam logic signed [XW-1:0] HI = XW'(SPEED_MAX);

    logic                 use_local;
    logic                 add;
    logic [PW-1:0]        src;
    logic signed [XW-1:0] src_x;
    logic signed [XW-1:0] mag_x;
    logic signed [XW-1:0] raw;
    logic signed [XW-1:0] clamped;
    logic                 unused_hi;

    // Select shooter power, apply wind, clamp to the speed window
    always_comb begin
        use_local = (player == PLAYER_1) ~^ (turn == 1'b0);
        src       = use_local ? in_power : power;
        add       = wind[WW] ^ turn;
        src_x     = signed'({2'b00, src});
        mag_x     = signed'({{(XW-WW){1'b0}}, wind[WW-1:0]});
        raw       = add ? (src_x + mag_x) : (src_x - mag_x);
        clamped   = raw;
        saturated = 1'b0;
        if (raw < LO) begin
            clamped   = LO;
            saturated = 1'b1;
        end else if (raw > HI) begin
            clamped   = HI;
            saturated = 1'b1;
        end
        result = clamped[PW-1:0];
    end

    assign unused_hi = ^clamped[XW-1:PW];

endmodule

// File: rtl/speed_calc.sv
// Per-shot speed setter: latches a launch, computes the wind-adjusted
// speed and holds it (with frame-tick drag) until the projectile hits.
module speed_calc
    import variable_pkg::*;
#(
    parameter int PW          = 5,
    parameter int WW          = 2,
    parameter int SPEED_MIN   = 1,
    parameter int SPEED_MAX   = 31,
    parameter int DRAG_PERIOD = 8
) (
    input  logic        clk60MHz,
    input  logic        rst_n,
    speed_calc_if.slave bus
);
    localparam int CW = (DRAG_PERIOD > 1) ? $clog2(DRAG_PERIOD) : 1;
    localparam bit DRAG_ON = (DRAG_PERIOD != 0);
    localparam logic [CW-1:0] DRAG_LAST = CW'(DRAG_PERIOD - 1);
    localparam logic [PW-1:0] SMIN = PW'(SPEED_MIN);

    speed_state_t  state_q;
    speed_state_t  state_d;
    logic          accept;
    logic          player_ok;

    logic [1:0]    player_l;
    logic          turn_l;
    logic [PW-1:0] in_power_l;
    logic [PW-1:0] power_l;
    logic [WW:0]   wind_l;

    logic [PW-1:0] calc_speed;
    logic          calc_sat;
    logic [PW-1:0] speed_q;
    logic          valid_q;
    logic          sat_q;
    logic [CW-1:0] drag_cnt;

    assign player_ok = (bus.current_player == PLAYER_1) ||
                       (bus.current_player == PLAYER_2);
    assign accept    = bus.launch && player_ok && (state_q == IDLE);

    // State register
    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: launch, one compute cycle, flight until hit
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    state_d = FLIGHT;
            FLIGHT:  if (bus.hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture shot inputs when the launch is accepted
    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            player_l   <= '0;
            turn_l     <= 1'b0;
            in_power_l <= '0;
            power_l    <= '0;
            wind_l     <= '0;
        end else if (accept) begin
            player_l   <= bus.current_player;
            turn_l     <= bus.turn;
            in_power_l <= bus.in_power;
            power_l    <= bus.power;
            wind_l     <= bus.wind;
        end
    end

    wind_apply #(
        .PW        (PW),
        .WW        (WW),
        .SPEED_MIN (SPEED_MIN),
        .SPEED_MAX (SPEED_MAX)
    ) u_wind (
        .player    (player_l),
        .turn      (turn_l),
        .in_power  (in_power_l),
        .power     (power_l),
        .wind      (wind_l),
        .result    (calc_speed),
        .saturated (calc_sat)
    );

    // Speed register: load after CALC, drag in flight, hit ends flight
    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            speed_q  <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            drag_cnt <= '0;
        end else if (state_q == CALC) begin
            speed_q  <= calc_speed;
            sat_q    <= calc_sat;
            valid_q  <= 1'b1;
            drag_cnt <= '0;
        end else if (state_q == FLIGHT) begin
            if (bus.hit) begin
                valid_q  <= 1'b0;
                drag_cnt <= '0;
            end else if (bus.frame_tick && DRAG_ON) begin
                if (drag_cnt == DRAG_LAST) begin
                    drag_cnt <= '0;
                    if (speed_q > SMIN) speed_q <= speed_q - PW'(1);
                end else begin
                    drag_cnt <= drag_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.launch_ready = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.speed        = speed_q;
    assign bus.speed_valid  = valid_q;
    assign bus.saturated    = sat_q;

endmodule

// File: tb/tb_speed_calc.sv
// Self-checking bench for speed_calc: vector table with a result
// scoreboard plus hand-written drag, hit, ignore and reset sequences.
module tb_speed_calc;
    import variable_pkg::*;

    localparam int PW = 5;
    localparam int WW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    speed_calc_if #(.PW(PW), .WW(WW)) bus ();

    speed_calc #(
        .PW          (PW),
        .WW          (WW),
        .SPEED_MIN   (1),
        .SPEED_MAX   (31),
        .DRAG_PERIOD (2)
    ) dut (
        .clk60MHz (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    typedef struct {
        logic [1:0]    player;
        logic          turn;
        logic [PW-1:0] in_power;
        logic [PW-1:0] power;
        logic [WW:0]   wind;
        logic [PW-1:0] exp_speed;
        logic          exp_sat;
    } vec_t;

    typedef struct {
        logic [PW-1:0] speed;
        logic          sat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic launch_shot(input vec_t v, input bit mutate);
        @(negedge clk);
        bus.current_player = v.player;
        bus.turn           = v.turn;
        bus.in_power       = v.in_power;
        bus.power          = v.power;
        bus.wind           = v.wind;
        bus.launch         = 1'b1;
        sb.push_back('{v.exp_speed, v.exp_sat});
        @(negedge clk);
        bus.launch = 1'b0;
        if (mutate) begin
            bus.turn     = ~bus.turn;
            bus.in_power = ~bus.in_power;
            bus.power    = ~bus.power;
            bus.wind     = ~bus.wind;
        end
        check("calc_busy", int'(bus.busy), 1);
        check("calc_valid", int'(bus.speed_valid), 0);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got result expected none queued", name);
        end else begin
            e = sb.pop_front();
            check({name, "_speed"}, int'(bus.speed), int'(e.speed));
            check({name, "_sat"}, int'(bus.saturated), int'(e.sat));
        end
    endtask

    task automatic wait_result(input string name);
        int cyc;
        cyc = 0;
        while (!bus.speed_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.speed_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no speed_valid expected 1", name);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            check({name, "_lat"}, cyc, 1);
            pop_check(name);
        end
    endtask

    task automatic pulse(input logic t, input logic h);
        @(negedge clk);
        bus.frame_tick = t;
        bus.hit        = h;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.hit        = 1'b0;
    endtask

    task automatic end_flight(input string name);
        pulse(1'b0, 1'b1);
        check({name, "_valid"}, int'(bus.speed_valid), 0);
        check({name, "_busy"}, int'(bus.busy), 0);
        check({name, "_ready"}, int'(bus.launch_ready), 1);
    endtask

    initial begin
        bus.launch         = 1'b0;
        bus.current_player = 2'b00;
        bus.turn           = 1'b0;
        bus.in_power       = '0;
        bus.power          = '0;
        bus.wind           = '0;
        bus.frame_tick     = 1'b0;
        bus.hit            = 1'b0;

        vecs[0] = '{PLAYER_1, 1'b0, 5'd20, 5'd9,  3'b110, 5'd22, 1'b0};
        vecs[1] = '{PLAYER_2, 1'b0, 5'd25, 5'd2,  3'b011, 5'd1,  1'b1};
        vecs[2] = '{PLAYER_1, 1'b1, 5'd3,  5'd30, 3'b010, 5'd31, 1'b1};
        vecs[3] = '{PLAYER_1, 1'b1, 5'd7,  5'd30, 3'b110, 5'd28, 1'b0};
        vecs[4] = '{PLAYER_2, 1'b1, 5'd10, 5'd20, 3'b101, 5'd9,  1'b0};
        vecs[5] = '{PLAYER_2, 1'b0, 5'd12, 5'd0,  3'b000, 5'd1,  1'b1};
        vecs[6] = '{PLAYER_1, 1'b0, 5'd31, 5'd4,  3'b111, 5'd31, 1'b1};
        vecs[7] = '{PLAYER_2, 1'b0, 5'd5,  5'd15, 3'b100, 5'd15, 1'b0};

        // Reset values
        #12;
        check("rst_speed", int'(bus.speed), 0);
        check("rst_valid", int'(bus.speed_valid), 0);
        check("rst_sat", int'(bus.saturated), 0);
        check("rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", int'(bus.launch_ready), 1);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            launch_shot(vecs[i], i == 3);
            wait_result($sformatf("vec%0d", i));
            check($sformatf("vec%0d_ready", i), int'(bus.launch_ready), 0);
            end_flight($sformatf("vec%0d_hit", i));
            check($sformatf("vec%0d_hold", i), int'(bus.speed),
                  int'(vecs[i].exp_speed));
        end

        // Drag: two ticks per decrement
        launch_shot(vecs[0], 1'b0);
        wait_result("drag");
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("drag_t2", int'(bus.speed), 21);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("drag_t4", int'(bus.speed), 20);
        pulse(1'b1, 1'b0);
        check("drag_t5", int'(bus.speed), 20);
        end_flight("drag_hit");
        check("drag_hold", int'(bus.speed), 20);

        // hit and frame_tick together on a decrement boundary
        launch_shot(vecs[0], 1'b0);
        wait_result("simul");
        pulse(1'b1, 1'b0);
        check("simul_t1", int'(bus.speed), 22);
        pulse(1'b1, 1'b1);
        check("simul_speed", int'(bus.speed), 22);
        check("simul_valid", int'(bus.speed_valid), 0);
        check("simul_ready", int'(bus.launch_ready), 1);

        // Launch while in flight is ignored
        launch_shot(vecs[0], 1'b0);
        wait_result("busy");
        @(negedge clk);
        bus.current_player = PLAYER_2;
        bus.in_power       = 5'd3;
        bus.power          = 5'd3;
        bus.launch         = 1'b1;
        @(negedge clk);
        bus.launch = 1'b0;
        @(negedge clk);
        check("busy_speed", int'(bus.speed), 22);
        check("busy_ready", int'(bus.launch_ready), 0);
        check("busy_valid", int'(bus.speed_valid), 1);
        end_flight("busy_hit");

        // Invalid player codes are ignored
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.current_player = (i == 0) ? 2'b00 : 2'b11;
            bus.launch         = 1'b1;
            @(negedge clk);
            bus.launch = 1'b0;
            check($sformatf("badp%0d_ready", i), int'(bus.launch_ready), 1);
            check($sformatf("badp%0d_busy", i), int'(bus.busy), 0);
        end

        // hit in IDLE, then hit during CALC
        pulse(1'b0, 1'b1);
        check("idle_hit_ready", int'(bus.launch_ready), 1);
        launch_shot(vecs[7], 1'b0);
        bus.hit = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
        check("calc_hit_valid", int'(bus.speed_valid), 1);
        pop_check("calc_hit");
        end_flight("calc_hit_end");

        // Asynchronous reset mid-flight
        launch_shot(vecs[2], 1'b0);
        wait_result("arst");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_speed", int'(bus.speed), 0);
        check("arst_valid", int'(bus.speed_valid), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_sat", int'(bus.saturated), 0);
        @(negedge clk);
        rst_n = 1'b1;
        launch_shot(vecs[7], 1'b0);
        wait_result("post_rst");
        end_flight("post_rst_hit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
